id_pipelined: RTL

ID_PIPELINED -- requirements
Module: id_pipelined

---
 rtl/id_pipelined_pkg.sv | 90 +++++++++
 rtl/registers_bank.sv | 45 ++++
 rtl/id_pipelined.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/id_pipelined_pkg.sv
// Shared decode constants, control-word layout and FSM encoding for the ID stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package id_pipelined_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // Control field encodings
  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;
  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [1:0] WB_SRC_LINK = 2'd2;
  localparam logic [1:0] ALU_SRC_REG = 2'd0;
  localparam logic [1:0] ALU_SRC_IMM = 2'd1;
  localparam logic [2:0] ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] ALU_OP_SUB   = 3'd1;
  localparam logic [2:0] ALU_OP_RTYPE = 3'd2;

  // Control word; field order fixes the bit offsets of o_ctrl (reg_write is bit 11)
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Opcode/funct to control word; J, HALT and unknown opcodes give all-zero control
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        if (funct != FUNCT_JR) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = REG_DST_RD;
          c.mem_to_reg = WB_SRC_ALU;
          c.alu_src    = ALU_SRC_REG;
          c.alu_op     = ALU_OP_RTYPE;
        end
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.reg_dst    = REG_DST_RT;
        c.mem_to_reg = WB_SRC_MEM;
        c.alu_src    = ALU_SRC_IMM;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = ALU_SRC_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.alu_src = ALU_SRC_REG;
        c.alu_op  = ALU_OP_SUB;
      end
      OP_JAL: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_R31;
        c.mem_to_reg = WB_SRC_LINK;
        c.alu_op     = ALU_OP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/registers_bank.sv
// General-purpose register file, two read ports with write-through bypass, r0 hardwired to zero.
// Latency: reads combinational, write lands on the next rising edge.
// Backpressure: none; a write strobe is always accepted.
module registers_bank #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int BUS_SIZE            = 32
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_write_enable,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]   i_write_addr,
  input  logic [BUS_SIZE-1:0]                      i_write_data,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]   i_read_addr_a,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]   i_read_addr_b,
  output logic [BUS_SIZE-1:0]                      o_read_data_a,
  output logic [BUS_SIZE-1:0]                      o_read_data_b,
  output logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0]  o_bus_debug
);

  logic [BUS_SIZE-1:0] regs [REGISTERS_BANK_SIZE];

  // Storage: r0 is never written so it stays at its reset value of zero
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < REGISTERS_BANK_SIZE; i++) regs[i] <= '0;
    end else if (i_write_enable && (i_write_addr != '0)) begin
      regs[i_write_addr] <= i_write_data;
    end
  end

  // Read ports: a same-cycle write to the read address is forwarded
  always_comb begin
    o_read_data_a = regs[i_read_addr_a];
    o_read_data_b = regs[i_read_addr_b];
    if (i_read_addr_a == '0) o_read_data_a = '0;
    else if (i_write_enable && (i_write_addr == i_read_addr_a)) o_read_data_a = i_write_data;
    if (i_read_addr_b == '0) o_read_data_b = '0;
    else if (i_write_enable && (i_write_addr == i_read_addr_b)) o_read_data_b = i_write_data;
  end

  for (genvar g = 0; g < REGISTERS_BANK_SIZE; g++) begin : g_debug
    assign o_bus_debug[g*BUS_SIZE +: BUS_SIZE] = regs[g];
  end

endmodule

// File: rtl/id_pipelined.sv
// Instruction decode stage: decode, register read, hazard detection, branch/jump redirect, ID/EX register.
// Latency: one cycle to the ID/EX register; redirect and o_ready are combinational.
// Backpressure: i_stall holds the register with o_ready low; hazards and HALTED insert bubbles with o_ready low.
module id_pipelined
  import id_pipelined_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int PC_SIZE             = 32,
  parameter int BUS_SIZE            = 32
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_valid,
  input  logic [BUS_SIZE-1:0]                      i_instruction,
  input  logic [PC_SIZE-1:0]                       i_next_seq_pc,
  input  logic                                     i_stall,
  input  logic                                     i_flush,
  input  logic                                     i_wb_write_enable,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]   i_wb_addr,
  input  logic [BUS_SIZE-1:0]                      i_wb_data,
  input  logic                                     i_ex_reg_write,
  input  logic                                     i_ex_mem_read,
  input  logic [4:0]                               i_ex_wr_addr,
  output logic                                     o_ready,
  output logic                                     o_valid,
  output logic [11:0]                              o_ctrl,
  output logic [BUS_SIZE-1:0]                      o_bus_a,
  output logic [BUS_SIZE-1:0]                      o_bus_b,
  output logic [BUS_SIZE-1:0]                      o_imm_ext,
  output logic [4:0]                               o_rs,
  output logic [4:0]                               o_rt,
  output logic [4:0]                               o_rd,
  output logic                                     o_next_pc_src,
  output logic [PC_SIZE-1:0]                       o_next_not_seq_pc,
  output logic                                     o_halted,
  output logic [31:0]                              o_stall_count,
  output logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0]  o_bus_debug
);

  localparam int ADDR_W = $clog2(REGISTERS_BANK_SIZE);

  logic [5:0]          op, funct;
  logic [4:0]          rs, rt, rd;
  logic [15:0]         imm;
  logic [25:0]         dir;
  logic [BUS_SIZE-1:0] rdata_a, rdata_b;
  logic [PC_SIZE-1:0]  br_target, jmp_target;
  ctrl_t               dec_ctrl;
  logic                is_jr, uses_rt, ex_src_match, load_use, branch_dep, hazard;
  state_t              state_q, state_d;
  logic                hold, load_instr, count_inc, accept;

  assign op    = i_instruction[31:26];
  assign rs    = i_instruction[25:21];
  assign rt    = i_instruction[20:16];
  assign rd    = i_instruction[15:11];
  assign imm   = i_instruction[15:0];
  assign funct = i_instruction[5:0];
  assign dir   = i_instruction[25:0];

  registers_bank #(
    .REGISTERS_BANK_SIZE (REGISTERS_BANK_SIZE),
    .BUS_SIZE            (BUS_SIZE)
  ) u_registers_bank (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_write_enable (i_wb_write_enable),
    .i_write_addr   (i_wb_addr),
    .i_write_data   (i_wb_data),
    .i_read_addr_a  (rs[ADDR_W-1:0]),
    .i_read_addr_b  (rt[ADDR_W-1:0]),
    .o_read_data_a  (rdata_a),
    .o_read_data_b  (rdata_b),
    .o_bus_debug    (o_bus_debug)
  );

  assign dec_ctrl = decode_ctrl(op, funct);
  assign is_jr    = (op == OP_RTYPE) && (funct == FUNCT_JR);
  assign uses_rt  = ((op == OP_RTYPE) && !is_jr) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

  // rs is always compared; rt only when the instruction actually reads it
  assign ex_src_match = (i_ex_wr_addr != 5'd0) &&
                        ((i_ex_wr_addr == rs) || (uses_rt && (i_ex_wr_addr == rt)));
  assign load_use     = i_ex_mem_read && ex_src_match;
  // Branches resolve in ID, so any in-flight ALU result they read is not yet available
  assign branch_dep   = ((op == OP_BEQ) || (op == OP_BNE) || is_jr) && i_ex_reg_write && ex_src_match;
  assign hazard       = i_valid && (load_use || branch_dep);

  assign br_target  = i_next_seq_pc + PC_SIZE'($signed({imm, 2'b00}));
  assign jmp_target = PC_SIZE'({i_next_seq_pc[PC_SIZE-1 -: 4], dir, 2'b00});

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Next state, handshake and ID/EX register action (hold / load / otherwise bubble)
  always_comb begin
    state_d    = state_q;
    o_ready    = 1'b0;
    hold       = 1'b0;
    load_instr = 1'b0;
    count_inc  = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_flush) begin
          o_ready = 1'b1;
        end else if (i_stall) begin
          hold = 1'b1;
        end else if (hazard) begin
          count_inc = 1'b1;
        end else begin
          o_ready = i_valid;
          accept  = i_valid;
          if (i_valid) begin
            if (op == OP_HALT) state_d = ST_HALTED;
            else               load_instr = 1'b1;
          end
        end
      end
      default: ;  // HALTED: bubbles, not ready, left only through reset
    endcase
  end

  // Redirect to IF for accepted control-flow instructions
  always_comb begin
    o_next_pc_src     = 1'b0;
    o_next_not_seq_pc = '0;
    if (accept) begin
      case (op)
        OP_BEQ: if (rdata_a == rdata_b) begin
          o_next_pc_src     = 1'b1;
          o_next_not_seq_pc = br_target;
        end
        OP_BNE: if (rdata_a != rdata_b) begin
          o_next_pc_src     = 1'b1;
          o_next_not_seq_pc = br_target;
        end
        OP_J, OP_JAL: begin
          o_next_pc_src     = 1'b1;
          o_next_not_seq_pc = jmp_target;
        end
        OP_RTYPE: if (funct == FUNCT_JR) begin
          o_next_pc_src     = 1'b1;
          o_next_not_seq_pc = PC_SIZE'(rdata_a);
        end
        default: ;
      endcase
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_ctrl    <= '0;
      o_bus_a   <= '0;
      o_bus_b   <= '0;
      o_imm_ext <= '0;
      o_rs      <= '0;
      o_rt      <= '0;
      o_rd      <= '0;
    end else if (hold) begin
      o_valid <= o_valid;
    end else if (load_instr) begin
      o_valid   <= 1'b1;
      o_ctrl    <= dec_ctrl;
      o_bus_a   <= (op == OP_JAL) ? BUS_SIZE'(i_next_seq_pc) : rdata_a;
      o_bus_b   <= rdata_b;
      o_imm_ext <= BUS_SIZE'($signed(imm));
      o_rs      <= rs;
      o_rt      <= rt;
      o_rd      <= rd;
    end else begin
      o_valid   <= 1'b0;
      o_ctrl    <= '0;
      o_bus_a   <= '0;
      o_bus_b   <= '0;
      o_imm_ext <= '0;
      o_rs      <= '0;
      o_rt      <= '0;
      o_rd      <= '0;
    end
  end

  // Saturating count of hazard bubbles
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                 o_stall_count <= '0;
    else if (count_inc && (o_stall_count != '1)) o_stall_count <= o_stall_count + 32'd1;
  end

  assign o_halted = (state_q == ST_HALTED);

endmodule
